lieat_ifu_imem_rsp: RTL
=======================

Name: lieat_ifu_imem_rsp

Overview:
Memory-side read responder for the instruction-fetch read channel (araddr/arvalid/arready, rdata/rvalid/rready). It accepts word read requests from the icache and queues them in order. Each request is answered from an internal word array after a fixed latency, and stalls are honoured on both channels. A side load port preloads program images. The block serves as the instruction memory model and, later, as the basis for the on-chip boot ROM/SRAM.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data/word width
MEM_DEPTH, 1024, number of DATA_W words in the array (power of 2)
BASE_ADDR, 32'h8000_0000, byte address mapped to word 0
LATENCY, 2, cycles from request acceptance to earliest rvalid (legal range 1..15)
FIFO_DEPTH, 2, maximum outstanding requests (power of 2, at least 1)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
s_axi_araddr  in  ADDR_W  byte read address
s_axi_arvalid  in  1  read request valid
s_axi_arready  out  1  request can be accepted
s_axi_rdata  out  DATA_W  read data
s_axi_rvalid  out  1  read response valid
s_axi_rready  in  1  requester accepts response
ld_en  in  1  preload write enable
ld_addr  in  ADDR_W  preload byte address
ld_data  in  DATA_W  preload word

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst), sampled on the rising edge of clk.
- Reset state: queue empty, all entry timers cleared, s_axi_rvalid=0, s_axi_rdata=0, s_axi_arready=0 while rst=1.
  - The array is not cleared by reset.
  - Requests outstanding when reset asserts are discarded. No response is issued for them.
- Word index = (addr - BASE_ADDR) >> 2, truncated to log2(MEM_DEPTH) bits, so out-of-range addresses wrap. addr[1:0] is ignored.
- Request queue: circular FIFO of FIFO_DEPTH entries, each holding {word index, 4-bit timer}. Uses separate read/write pointers plus a count.
- s_axi_arready = (count != FIFO_DEPTH) & ~rst. The signal is combinational from registered count.
  - No bypass: when full, a same-cycle pop does not allow a same-cycle accept.
- Accept (arvalid & arready): push entry with timer=LATENCY-1.
  - Every cycle, each valid entry's timer decrements, saturating at 0.
- s_axi_rvalid = queue non-empty & head timer==0.
- s_axi_rdata = mem[head index] while rvalid=1, otherwise 0.
  - The read is combinational at response time, so a ld write to that word shows its new value from the next cycle.
- Pop on rvalid & rready. At most one response per cycle, issued in request order.
- Once rvalid=1, rvalid stays 1 and rdata stays stable until rready. The only exception is a ld_en write to the same word, which the requester must not perform during fetch.
- Every accepted request gets exactly one response, with no cancellation. The icache relies on this to drain stale responses after a flush.
- Simultaneous push and pop when not full: count is unchanged and both pointers advance.
- LATENCY=1 with rready held at 1 sustains one response per cycle after the first. A request accepted in cycle N responds in cycle N+1.
- ld_en: mem[index(ld_addr)] <= ld_data on the clock edge. The same index wrap rules apply. The write is independent of the queue and takes effect even during rst.

Optional Feature:
- Macro LIEAT_IMEM_RESP_ERR_EN.
- When defined:
  - Adds output s_axi_rresp [1:0].
  - Each entry also stores an out-of-range flag, set when addr < BASE_ADDR or addr >= BASE_ADDR + 4*MEM_DEPTH.
  - Flagged responses give rresp=2'b10 (SLVERR) and rdata=0. Normal responses give rresp=2'b00.
  - rresp is 0 when rvalid=0 and holds with rdata.
- When undefined: no rresp port; out-of-range addresses wrap as above.

Test Plan:
- Preload mem[0]=32'h0000_0013 via ld at 32'h8000_0000, LATENCY=2, rready=1; arvalid with addr 32'h8000_0000 accepted in cycle 0 -> rvalid=1 with rdata=32'h0000_0013 in cycle 2 only, then rvalid=0.
- FIFO_DEPTH=2, three back-to-back requests to 32'h8000_0000/4/8 with rready=1 -> arready low after 2 accepts until the first pop; responses returned in order with data words 0, 1, 2.
- Response pending with rready=0 for 5 cycles -> rvalid stays 1 and rdata constant; pop occurs on the first cycle rready=1.
- rst asserted with 2 requests outstanding -> rvalid=0 and arready=0 in the next cycle; after release arready=1, no stale response appears, and a new request returns correct data.
- Request to 32'h0000_0000 -> without the macro, returns mem[0] (wrap); with LIEAT_IMEM_RESP_ERR_EN, returns rresp=2'b10, rdata=0, and the next in-range request returns rresp=2'b00.
- ld write mem[3]=32'hDEAD_BEEF while a request to 32'h8000_000C is queued with timer >0 -> the response carries 32'hDEAD_BEEF.

Source files
------------

// File: rtl/lieat_ifu_imem_rsp_if.sv
// Instruction-fetch read channel between the icache (master) and the imem responder (slave).
// s_axi_rresp is present only when LIEAT_IMEM_RESP_ERR_EN is defined.
interface lieat_ifu_imem_rsp_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) ();

  logic [ADDR_W-1:0] s_axi_araddr;
  logic              s_axi_arvalid;
  logic              s_axi_arready;
  logic [DATA_W-1:0] s_axi_rdata;
  logic              s_axi_rvalid;
  logic              s_axi_rready;
`ifdef LIEAT_IMEM_RESP_ERR_EN
  logic [1:0]        s_axi_rresp;

  modport master (
    output s_axi_araddr, s_axi_arvalid, s_axi_rready,
    input  s_axi_arready, s_axi_rdata, s_axi_rvalid, s_axi_rresp
  );

  modport slave (
    input  s_axi_araddr, s_axi_arvalid, s_axi_rready,
    output s_axi_arready, s_axi_rdata, s_axi_rvalid, s_axi_rresp
  );
`else
  modport master (
    output s_axi_araddr, s_axi_arvalid, s_axi_rready,
    input  s_axi_arready, s_axi_rdata, s_axi_rvalid
  );

  modport slave (
    input  s_axi_araddr, s_axi_arvalid, s_axi_rready,
    output s_axi_arready, s_axi_rdata, s_axi_rvalid
  );
`endif

endinterface

// File: rtl/lieat_ifu_imem_rsp.sv
// Instruction memory responder: in-order fixed-latency word reads from a preloadable array.
// Optional macro LIEAT_IMEM_RESP_ERR_EN flags out-of-range requests with SLVERR on rresp.
module lieat_ifu_imem_rsp #(
  parameter int unsigned       ADDR_W     = 32,
  parameter int unsigned       DATA_W     = 32,
  parameter int unsigned       MEM_DEPTH  = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = 32'h8000_0000,
  parameter int unsigned       LATENCY    = 2,
  parameter int unsigned       FIFO_DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst,
  lieat_ifu_imem_rsp_if.slave bus,
  input  logic                ld_en,
  input  logic [ADDR_W-1:0]   ld_addr,
  input  logic [DATA_W-1:0]   ld_data
);

  localparam int unsigned IdxW = $clog2(MEM_DEPTH);
  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned TmrW = 4;
  localparam logic [TmrW-1:0] TmrInit = TmrW'(LATENCY - 1);

  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("LATENCY must be in 1..15");
  end
  if (FIFO_DEPTH == 0 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fifo_depth
    $error("FIFO_DEPTH must be a non-zero power of 2");
  end

  typedef struct packed {
`ifdef LIEAT_IMEM_RESP_ERR_EN
    logic            oor;
`endif
    logic [IdxW-1:0] idx;
    logic [TmrW-1:0] tmr;
  } entry_t;

  logic [DATA_W-1:0] mem_q [MEM_DEPTH];

  entry_t          ent_q [FIFO_DEPTH];
  entry_t          ent_d [FIFO_DEPTH];
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic [ADDR_W-1:0] ar_off, ld_off;
  logic [IdxW-1:0]   ar_idx, ld_idx;
  logic              unused_off_bits;

  entry_t          head;
  logic            full, arready, rvalid, push, pop;
  logic [PtrW-1:0] slot_off;

  // Byte offset from the base; the word index is taken modulo MEM_DEPTH so addresses wrap.
  assign ar_off = bus.s_axi_araddr - BASE_ADDR;
  assign ld_off = ld_addr - BASE_ADDR;
  assign ar_idx = ar_off[IdxW+1:2];
  assign ld_idx = ld_off[IdxW+1:2];

  assign unused_off_bits = ^{ar_off[1:0], ar_off[ADDR_W-1:IdxW+2],
                             ld_off[1:0], ld_off[ADDR_W-1:IdxW+2]};

`ifdef LIEAT_IMEM_RESP_ERR_EN
  logic ar_oor;
  assign ar_oor = (bus.s_axi_araddr < BASE_ADDR) || (ar_off[ADDR_W-1:IdxW+2] != '0);
`endif

  assign head    = ent_q[rd_ptr_q];
  // No bypass: a full queue refuses requests even while it is popping.
  assign full    = (cnt_q == CntW'(FIFO_DEPTH));
  assign arready = ~full & ~rst;
  assign rvalid  = ~rst & (cnt_q != '0) & (head.tmr == '0);
  assign push    = bus.s_axi_arvalid & arready;
  assign pop     = rvalid & bus.s_axi_rready;

  assign bus.s_axi_arready = arready;
  assign bus.s_axi_rvalid  = rvalid;

  always_comb begin
    bus.s_axi_rdata = '0;
`ifdef LIEAT_IMEM_RESP_ERR_EN
    bus.s_axi_rresp = 2'b00;
    if (rvalid) begin
      if (head.oor) begin
        bus.s_axi_rresp = 2'b10;
      end else begin
        bus.s_axi_rdata = mem_q[head.idx];
      end
    end
`else
    if (rvalid) begin
      bus.s_axi_rdata = mem_q[head.idx];
    end
`endif
  end

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    ent_d    = ent_q;
    slot_off = '0;
    // Age every live entry; distance from the read pointer tells whether a slot is occupied.
    for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
      slot_off = PtrW'(i) - rd_ptr_q;
      if ((CntW'(slot_off) < cnt_q) && (ent_q[i].tmr != '0)) begin
        ent_d[i].tmr = ent_q[i].tmr - 1'b1;
      end
    end
    if (push) begin
      ent_d[wr_ptr_q].idx = ar_idx;
      ent_d[wr_ptr_q].tmr = TmrInit;
`ifdef LIEAT_IMEM_RESP_ERR_EN
      ent_d[wr_ptr_q].oor = ar_oor;
`endif
    end

    rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;

    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        ent_q[i] <= '0;
      end
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      ent_q    <= ent_d;
    end
  end

  // Preload port is independent of the queue and of reset.
  always_ff @(posedge clk) begin
    if (ld_en) begin
      mem_q[ld_idx] <= ld_data;
    end
  end

endmodule
